// File: rtl/tridiag_result_collector_pkg.sv
// Shared definitions for the cluster Jacobi matrix-by-vector path.
// Holds the collector state encoding, a ceil-div helper and the derived
// padding constants (additional, total, no_of_beats). The matrix-by-vector
// and decoder blocks use the same functions, so all blocks agree on the
// padded row count and the number of beats per vector.
package tridiag_result_collector_pkg;

  localparam logic [31:0] zero_filling = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } collector_state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // A row count that is already a multiple of NI still gets a full NI of
  // padding; the producer side is built around that, so keep it.
  function automatic int calc_additional(input int eqn, input int ni);
    return ni - (eqn % ni);
  endfunction

  function automatic int calc_total(input int eqn, input int ni);
    return eqn + calc_additional(eqn, ni);
  endfunction

  function automatic int calc_no_of_beats(input int eqn, input int ni, input int units);
    return ceil_div(calc_total(eqn, ni), 2 * units);
  endfunction

endpackage

// File: rtl/tridiag_result_collector_beat_row_placer.sv
// Combinational placement of one result beat into the row space.
// Ports:
//   beat_idx  - index of the beat being presented
//   in_data   - packed beat, MSB slot = lowest row of the beat
//   row_we    - per-row write enable, bit r = row r
//   row_data  - per-row data in out_vector layout (MSB slot = row 0)
// Padding rows (r >= no_of_eqn_per_cluster) have no storage, so their
// slots simply never drive a row.
module tridiag_result_collector_beat_row_placer
  import tridiag_result_collector_pkg::*;
#(
  parameter int no_of_eqn_per_cluster = 10,
  parameter int element_width         = 32,
  parameter int no_of_units           = 4,
  parameter int cnt_width             = 2
) (
  input  logic [cnt_width-1:0]                             beat_idx,
  input  logic [2*element_width*no_of_units-1:0]           in_data,
  output logic [no_of_eqn_per_cluster-1:0]                 row_we,
  output logic [no_of_eqn_per_cluster*element_width-1:0]   row_data
);

  localparam int slots = 2 * no_of_units;

  for (genvar r = 0; r < no_of_eqn_per_cluster; r++) begin : g_row
    localparam int                   slot_of_row = r % slots;
    localparam logic [cnt_width-1:0] beat_of_row = cnt_width'(r / slots);

    assign row_we[r] = (beat_idx == beat_of_row);
    assign row_data[(no_of_eqn_per_cluster-1-r)*element_width +: element_width] =
      in_data[(slots-1-slot_of_row)*element_width +: element_width];
  end

endmodule

// File: rtl/tridiag_result_collector.sv
// Consumer end of the matrix-by-vector result interface.
// Reassembles packed result beats into the per-cluster result vector,
// discards the padding rows and raises a level finish when complete.
// Ports:
//   clk, reset         - rising-edge clock, synchronous active-high reset
//   start              - level enable; low returns to idle and clears flags
//   in_data            - result beat, MSB slot = lowest row index
//   outsider_read_now  - beat valid
//   out_vector         - assembled result, MSB slot = row 0
//   finish             - vector complete (level)
//   overflow           - sticky, a beat arrived after completion
module tridiag_result_collector
  import tridiag_result_collector_pkg::*;
#(
  parameter int no_of_eqn_per_cluster = 10,
  parameter int element_width         = 32,
  parameter int no_of_units           = 4,
  parameter int NI                    = 8
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic [2*element_width*no_of_units-1:0]         in_data,
  input  logic                                           outsider_read_now,
  output logic [no_of_eqn_per_cluster*element_width-1:0] out_vector,
  output logic                                           finish,
  output logic                                           overflow
);

  localparam int additional  = calc_additional(no_of_eqn_per_cluster, NI);
  localparam int total       = calc_total(no_of_eqn_per_cluster, NI);
  localparam int no_of_beats = calc_no_of_beats(no_of_eqn_per_cluster, NI, no_of_units);
  localparam int cnt_width   = $clog2(no_of_beats + 1);
  localparam logic [cnt_width-1:0] last_beat = cnt_width'(no_of_beats - 1);

  collector_state_t                             state_r;
  logic [cnt_width-1:0]                         beat_cnt_r;
  logic [no_of_eqn_per_cluster-1:0]             row_we_s;
  logic [no_of_eqn_per_cluster*element_width-1:0] row_data_s;

  tridiag_result_collector_beat_row_placer #(
    .no_of_eqn_per_cluster (no_of_eqn_per_cluster),
    .element_width         (element_width),
    .no_of_units           (no_of_units),
    .cnt_width             (cnt_width)
  ) u_placer (
    .beat_idx (beat_cnt_r),
    .in_data  (in_data),
    .row_we   (row_we_s),
    .row_data (row_data_s)
  );

  // Collector FSM, beat counter, result storage and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      beat_cnt_r <= '0;
      out_vector <= '0;
      finish     <= 1'b0;
      overflow   <= 1'b0;
    end else if (!start) begin
      // Dropping start abandons any partial vector but keeps the data.
      state_r    <= ST_IDLE;
      beat_cnt_r <= '0;
      finish     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Beats seen on the start-rising edge are dropped on purpose.
          state_r <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (outsider_read_now) begin
            for (int r = 0; r < no_of_eqn_per_cluster; r++) begin
              if (row_we_s[r]) begin
                out_vector[(no_of_eqn_per_cluster-1-r)*element_width +: element_width] <=
                  row_data_s[(no_of_eqn_per_cluster-1-r)*element_width +: element_width];
              end
            end
            beat_cnt_r <= beat_cnt_r + cnt_width'(1);
            if (beat_cnt_r == last_beat) begin
              state_r <= ST_DONE;
              finish  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (outsider_read_now) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          beat_cnt_r <= '0;
          finish     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tridiag_result_collector.md
Name: tridiag_result_collector

Overview:
- Consumer end of the matrix-by-vector result interface in the cluster Jacobi datapath.
- Accepts the packed result beats the decoder emits; each beat holds 2*no_of_units elements and is qualified by outsider_read_now.
- Reassembles the beats into the full per-cluster result vector and strips the NI padding rows.
- Raises a level finish once the vector is complete, so the next Jacobi iteration stage can latch it.

Parameters:
- no_of_eqn_per_cluster, 10, real equations (rows) per cluster.
- element_width, 32, bits per element.
- no_of_units, 4, row units in the producer; elements per beat = 2*no_of_units.
- NI, 8, padding granule.
- additional, NI-(no_of_eqn_per_cluster%NI), padding rows. When no_of_eqn_per_cluster%NI==0 this equals NI; keep that formula unchanged.
- total, no_of_eqn_per_cluster+additional, padded row count.
- no_of_beats, ceil(total/(2*no_of_units)), beats per vector.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  level enable; low means idle and clear
- in_data  in  2*element_width*no_of_units  result beat; MSB slot = lowest row index
- outsider_read_now  in  1  beat valid
- out_vector  out  no_of_eqn_per_cluster*element_width  assembled result; MSB slot = row 0
- finish  out  1  vector complete (level)
- overflow  out  1  sticky: beat arrived after completion

Behaviour:
- Reset:
  - out_vector=0, finish=0, overflow=0, beat counter=0, state=IDLE.
  - Reset wins over every other input.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - start=1 -> COLLECT on the next edge.
  - While in IDLE, outsider_read_now is ignored.
  - out_vector keeps its old contents.
- start=0 in any state:
  - Next edge -> IDLE, beat counter=0, finish=0.
  - overflow is cleared. out_vector is held.
- COLLECT:
  - On each edge with outsider_read_now=1, beat b (counter value) is accepted.
  - Slot k of the beat (k=0 is the MSB element) maps to row r = b*2*no_of_units + k.
  - Rows r < no_of_eqn_per_cluster are written into out_vector. Rows >= no_of_eqn_per_cluster are padding and are discarded.
  - Written elements are visible the cycle after acceptance.
  - Counter increments per accepted beat. Gaps in outsider_read_now are allowed, and the counter holds during them.
- Completion:
  - On the edge that accepts beat no_of_beats-1: state -> DONE and finish=1 (visible the next cycle, together with the final data).
- DONE:
  - finish stays 1 while start=1.
  - Any outsider_read_now=1 sets overflow=1. out_vector and the counter are unchanged.
- start and outsider_read_now rising on the same edge in IDLE: the beat is NOT accepted, because the state is still IDLE.
- The first cycle of start, taken in isolation, accepts nothing.
- Counter width: clog2(no_of_beats+1). It never wraps, because DONE freezes it.
- No arithmetic is performed on elements. This is pure placement.

Decomposition:
- Shared package (already holds zero_filling = 32'd0) gains:
  - the state encoding;
  - a ceil-div function;
  - derived-constant functions for additional, total and no_of_beats. These are shared with the matrix-by-vector and decoder blocks.
- One natural sub-module: beat_row_placer. It is combinational. Given the beat index and in_data, it produces per-row write enables and data for out_vector, including padding masking.
- The top level holds the FSM, counter, storage and flags.

Test Plan:
- Defaults (10 eqn, 2 beats):
  - Stimulus: start=1, wait 1 cycle. Beat0 slots = 1..8 (MSB first), then beat1 = 9..16 on consecutive cycles.
  - Response: out_vector rows 0..9 = 1..10; rows 10..15 are dropped. finish=1 the cycle after beat1.
- Gapped valid:
  - Stimulus: the same beats separated by 3 idle cycles.
  - Response: identical result; finish only after beat1.
- Overflow:
  - Stimulus: after finish, one more beat with all slots 0xFFFFFFFF.
  - Response: overflow=1, out_vector unchanged, finish stays 1.
- start drop mid-collection:
  - Stimulus: drop start after beat0, raise it again, then send beat0'=21..28 and beat1'=29..36.
  - Response: rows 0..9 = 21..30, finish=1; the stale counter is not used.
- Reset mid-operation:
  - Stimulus: assert reset after beat0.
  - Response: out_vector=0, finish=0, overflow=0 next cycle. A subsequent full sequence completes normally.
- Ignored beats:
  - Stimulus: outsider_read_now pulses while start=0, and on the start-rising cycle.
  - Response: no rows written, counter stays 0.
